// File: rtl/vga_fb_pkg.sv
// Shared constants and FSM encoding for the VGA frame-buffer arbiter slice.
// Geometry is fixed at 800x600 with one 8-bit word per pixel.
package vga_fb_pkg;

   localparam int H_ACTIVE = 800;
   localparam int V_ACTIVE = 600;
   localparam int FB_DEPTH = H_ACTIVE * V_ACTIVE;
   localparam int ADDR_W   = 19;
   localparam int PIX_W    = 8;
   localparam int COORD_W  = 11;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_ISSUE = 2'd1,
      RD_WAIT  = 2'd2,
      WR_ISSUE = 2'd3
   } arb_state_e;

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Display, writer and frame-buffer signals of the arbiter as one bundle.
// The slave modport is the arbiter's view; master is the surrounding system.
interface vga_fb_arbiter_if;
   import vga_fb_pkg::*;

   logic               pix_stb;
   logic               disp_valid;
   logic [COORD_W-1:0] disp_col;
   logic [COORD_W-1:0] disp_row;
   logic               wr_req;
   logic [ADDR_W-1:0]  wr_addr;
   logic [PIX_W-1:0]   wr_data;
   logic               wr_ack;
   logic               wr_err;
   logic [ADDR_W-1:0]  mem_addr;
   logic               mem_we;
   logic [PIX_W-1:0]   mem_wdata;
   logic [PIX_W-1:0]   mem_rdata;
   logic [PIX_W-1:0]   pix_data;
   logic               pix_data_valid;
   logic               rd_overrun;

   modport slave (
      input  pix_stb, disp_valid, disp_col, disp_row,
      input  wr_req, wr_addr, wr_data, mem_rdata,
      output wr_ack, wr_err, mem_addr, mem_we, mem_wdata,
      output pix_data, pix_data_valid, rd_overrun
   );

   modport master (
      output pix_stb, disp_valid, disp_col, disp_row,
      output wr_req, wr_addr, wr_data, mem_rdata,
      input  wr_ack, wr_err, mem_addr, mem_we, mem_wdata,
      input  pix_data, pix_data_valid, rd_overrun
   );

endinterface

// File: rtl/vga_fb_addr_calc.sv
// Linear frame-buffer address from display coordinates: row*H_ACTIVE + col.
// For the 800-wide mode this is row*(512+256+32) + col, built from shifts.
module vga_fb_addr_calc
   import vga_fb_pkg::*;
#(
   parameter int H_ACTIVE = vga_fb_pkg::H_ACTIVE
) (
   input  logic [COORD_W-1:0] row,
   input  logic [COORD_W-1:0] col,
   output logic [ADDR_W-1:0]  addr
);

   logic [ADDR_W-1:0] row_w;
   logic [ADDR_W-1:0] col_w;

   // Widen before shifting so row<<9 keeps all its bits.
   assign row_w = ADDR_W'(row);
   assign col_w = ADDR_W'(col);

   if (H_ACTIVE == 800) begin : g_shift_add
      assign addr = (row_w << 9) + (row_w << 8) + (row_w << 5) + col_w;
   end else begin : g_mult
      assign addr = row_w * ADDR_W'(H_ACTIVE) + col_w;
   end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: display fetches have strict priority,
// the pixel writer fills the idle cycles left inside each 6-cycle pixel period.
module vga_fb_arbiter
   import vga_fb_pkg::*;
#(
   parameter int MEM_LAT  = 1,
   parameter int H_ACTIVE = vga_fb_pkg::H_ACTIVE,
   parameter int FB_DEPTH = vga_fb_pkg::FB_DEPTH
) (
   input logic             vga_clk,
   input logic             rst_n,
   vga_fb_arbiter_if.slave bus
);

   localparam logic [1:0]        LAT_M1 = 2'(MEM_LAT - 1);
   localparam logic [ADDR_W-1:0] DEPTH  = ADDR_W'(FB_DEPTH);

   arb_state_e        state_q, state_d;
   logic              pending_q, pending_d;
   logic              armed_q, armed_d;
   logic [1:0]        lat_cnt_q, lat_cnt_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              mem_we_q, mem_we_d;
   logic [PIX_W-1:0]  mem_wdata_q, mem_wdata_d;
   logic              wr_ack_q, wr_ack_d;
   logic              wr_err_q, wr_err_d;
   logic [PIX_W-1:0]  pix_data_q, pix_data_d;
   logic              pix_valid_q, pix_valid_d;
   logic              rd_overrun_q, rd_overrun_d;

   logic              fetch;
   logic [ADDR_W-1:0] fetch_addr;

   assign fetch = bus.pix_stb & bus.disp_valid;

   vga_fb_addr_calc #(.H_ACTIVE(H_ACTIVE)) u_addr_calc (
      .row  (bus.disp_row),
      .col  (bus.disp_col),
      .addr (fetch_addr)
   );

   // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      state_d      = state_q;
      pending_d    = pending_q;
      armed_d      = 1'b1;
      lat_cnt_d    = lat_cnt_q;
      mem_addr_d   = mem_addr_q;
      mem_we_d     = 1'b0;
      mem_wdata_d  = mem_wdata_q;
      wr_ack_d     = 1'b0;
      wr_err_d     = wr_err_q;
      pix_data_d   = pix_data_q;
      pix_valid_d  = 1'b0;
      rd_overrun_d = rd_overrun_q;

      unique case (state_q)
         IDLE: begin
            if (fetch) begin
               state_d    = RD_ISSUE;
               mem_addr_d = fetch_addr;
            end else if (bus.wr_req && armed_q) begin
               // Out-of-range writes are still acked so the writer never stalls.
               state_d     = WR_ISSUE;
               mem_addr_d  = bus.wr_addr;
               mem_wdata_d = bus.wr_data;
               wr_ack_d    = 1'b1;
               if (bus.wr_addr < DEPTH) mem_we_d = 1'b1;
               else                     wr_err_d = 1'b1;
            end
         end
         RD_ISSUE: begin
            if (fetch) rd_overrun_d = 1'b1;
            state_d   = RD_WAIT;
            lat_cnt_d = LAT_M1;
         end
         RD_WAIT: begin
            if (fetch) rd_overrun_d = 1'b1;
            if (lat_cnt_q == 2'd0) begin
               state_d     = IDLE;
               pix_data_d  = bus.mem_rdata;
               pix_valid_d = 1'b1;
               pending_d   = 1'b0;
            end else begin
               lat_cnt_d = lat_cnt_q - 2'd1;
            end
         end
         WR_ISSUE: begin
            // A strobe landing on the write slot is served right after it.
            if (fetch) begin
               state_d    = RD_ISSUE;
               mem_addr_d = fetch_addr;
               pending_d  = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
   always_ff @(posedge vga_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         pending_q    <= 1'b0;
         armed_q      <= 1'b0;
         lat_cnt_q    <= 2'd0;
         mem_addr_q   <= '0;
         mem_we_q     <= 1'b0;
         mem_wdata_q  <= '0;
         wr_ack_q     <= 1'b0;
         wr_err_q     <= 1'b0;
         pix_data_q   <= '0;
         pix_valid_q  <= 1'b0;
         rd_overrun_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pending_q    <= pending_d;
         armed_q      <= armed_d;
         lat_cnt_q    <= lat_cnt_d;
         mem_addr_q   <= mem_addr_d;
         mem_we_q     <= mem_we_d;
         mem_wdata_q  <= mem_wdata_d;
         wr_ack_q     <= wr_ack_d;
         wr_err_q     <= wr_err_d;
         pix_data_q   <= pix_data_d;
         pix_valid_q  <= pix_valid_d;
         rd_overrun_q <= rd_overrun_d;
      end
   end

   assign bus.mem_addr       = mem_addr_q;
   assign bus.mem_we         = mem_we_q;
   assign bus.mem_wdata      = mem_wdata_q;
   assign bus.wr_ack         = wr_ack_q;
   assign bus.wr_err         = wr_err_q;
   assign bus.pix_data       = pix_data_q;
   assign bus.pix_data_valid = pix_valid_q;
   assign bus.rd_overrun     = rd_overrun_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: MEM_LAT=1 and MEM_LAT=3 instances share stimulus;
// pixel reads of the MEM_LAT=1 instance go through an expected-value queue.
module tb_vga_fb_arbiter;
   import vga_fb_pkg::*;

   logic vga_clk = 1'b0;
   logic rst_n   = 1'b0;
   always #5 vga_clk = ~vga_clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge vga_clk) cyc <= cyc + 1;

   logic               pix_stb    = 1'b0;
   logic               disp_valid = 1'b0;
   logic [COORD_W-1:0] disp_col   = '0;
   logic [COORD_W-1:0] disp_row   = '0;
   logic               wr_req     = 1'b0;
   logic [ADDR_W-1:0]  wr_addr    = '0;
   logic [PIX_W-1:0]   wr_data    = '0;

   vga_fb_arbiter_if bus1 ();
   vga_fb_arbiter_if bus3 ();

   assign bus1.pix_stb    = pix_stb;
   assign bus1.disp_valid = disp_valid;
   assign bus1.disp_col   = disp_col;
   assign bus1.disp_row   = disp_row;
   assign bus1.wr_req     = wr_req;
   assign bus1.wr_addr    = wr_addr;
   assign bus1.wr_data    = wr_data;
   assign bus3.pix_stb    = pix_stb;
   assign bus3.disp_valid = disp_valid;
   assign bus3.disp_col   = disp_col;
   assign bus3.disp_row   = disp_row;
   assign bus3.wr_req     = wr_req;
   assign bus3.wr_addr    = wr_addr;
   assign bus3.wr_data    = wr_data;

   // Frame-buffer content is a fixed function of the address.
   function automatic logic [7:0] fmem(input logic [18:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   logic [18:0] a1 = '0;
   logic [18:0] a3 [3] = '{default: '0};
   always @(posedge vga_clk) begin
      a1    <= bus1.mem_addr;
      a3[0] <= bus3.mem_addr;
      a3[1] <= a3[0];
      a3[2] <= a3[1];
   end
   assign bus1.mem_rdata = fmem(a1);
   assign bus3.mem_rdata = fmem(a3[2]);

   vga_fb_arbiter #(.MEM_LAT(1)) dut1 (.vga_clk(vga_clk), .rst_n(rst_n), .bus(bus1.slave));
   vga_fb_arbiter #(.MEM_LAT(3)) dut3 (.vga_clk(vga_clk), .rst_n(rst_n), .bus(bus3.slave));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      logic [7:0] data;
      int         cyc;
   } pix_exp_t;

   pix_exp_t pix_q[$];
   pix_exp_t mon_e;

   always @(negedge vga_clk) begin
      if (rst_n && bus1.pix_data_valid) begin
         if (pix_q.size() == 0) begin
            check("pix_unexpected", 64'(bus1.pix_data_valid), 64'(0));
         end else begin
            mon_e = pix_q.pop_front();
            check("pix_data", 64'(bus1.pix_data), 64'(mon_e.data));
            check("pix_cycle", 64'(cyc), 64'(mon_e.cyc));
         end
      end
   end

   function automatic logic [63:0] outs1();
      return 64'({bus1.mem_addr, bus1.mem_we, bus1.mem_wdata, bus1.wr_ack,
                  bus1.wr_err, bus1.pix_data, bus1.pix_data_valid, bus1.rd_overrun});
   endfunction

   task automatic tick();
      @(posedge vga_clk);
      #1;
   endtask

   // Drives one display strobe in the current cycle N; returns in cycle N+1.
   task automatic fetch(input logic [10:0] row, input logic [10:0] col,
                        input logic [18:0] exp_addr, input bit expect_pix);
      pix_stb    = 1'b1;
      disp_valid = 1'b1;
      disp_row   = row;
      disp_col   = col;
      if (expect_pix) pix_q.push_back('{fmem(exp_addr), cyc + 3});
      tick();
      pix_stb    = 1'b0;
      disp_valid = 1'b0;
   endtask

   task automatic wait_ack(output int got);
      got = -1;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus1.wr_ack) begin
            got = cyc;
            break;
         end
      end
   endtask

   task automatic write_txn(input string name, input logic [18:0] addr, input logic [7:0] data,
                            input int exp_cyc, input logic exp_we);
      int got;
      wr_req  = 1'b1;
      wr_addr = addr;
      wr_data = data;
      wait_ack(got);
      wr_req = 1'b0;
      check({name, "_ack_cycle"}, 64'(got), 64'(exp_cyc));
      if (got >= 0) begin
         check({name, "_addr"}, 64'(bus1.mem_addr), 64'(addr));
         check({name, "_we"}, 64'(bus1.mem_we), 64'(exp_we));
         check({name, "_wdata"}, 64'(bus1.mem_wdata), 64'(data));
      end
      tick();
   endtask

   typedef struct {
      logic [10:0] row;
      logic [10:0] col;
      logic [18:0] addr;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int n;
      int got;
      bit seen;

      vecs = '{'{11'd0,   11'd5,   19'd5},
               '{11'd1,   11'd0,   19'd800},
               '{11'd599, 11'd799, 19'd479999},
               '{11'd0,   11'd0,   19'd0},
               '{11'd2,   11'd3,   19'd1603},
               '{11'd300, 11'd400, 19'd240400},
               '{11'd0,   11'd799, 19'd799},
               '{11'd598, 11'd0,   19'd478400}};

      // Reset values, then the first grant must wait for the second edge.
      wr_req  = 1'b1;
      wr_addr = 19'd10;
      wr_data = 8'h33;
      #12;
      check("reset_outs1", outs1(), 64'(0));
      check("reset_ack3", 64'(bus3.wr_ack), 64'(0));
      @(posedge vga_clk);
      #2;
      rst_n = 1'b1;
      tick();
      check("rel_edge1_ack", 64'(bus1.wr_ack), 64'(0));
      tick();
      check("rel_edge2_ack", 64'(bus1.wr_ack), 64'(1));
      check("rel_edge2_addr", 64'(bus1.mem_addr), 64'(10));
      check("rel_edge2_we", 64'(bus1.mem_we), 64'(1));
      wr_req = 1'b0;
      repeat (2) tick();

      // Address vectors, one fetch per 6-cycle pixel period.
      for (int i = 0; i < 8; i++) begin
         fetch(vecs[i].row, vecs[i].col, vecs[i].addr, 1'b1);
         check($sformatf("vec%0d_addr", i), 64'(bus1.mem_addr), 64'(vecs[i].addr));
         check($sformatf("vec%0d_we", i), 64'(bus1.mem_we), 64'(0));
         repeat (5) tick();
      end

      // Blanking strobe is ignored; the writer is granted on the next edge.
      pix_stb    = 1'b1;
      disp_valid = 1'b0;
      write_txn("blank_wr", 19'd200, 8'h44, cyc + 1, 1'b1);
      pix_stb = 1'b0;
      repeat (3) tick();

      // Collision: read wins, write granted after RD_WAIT ends.
      n       = cyc;
      wr_req  = 1'b1;
      wr_addr = 19'd100;
      wr_data = 8'h77;
      fetch(11'd0, 11'd9, 19'd9, 1'b1);
      check("coll_rd_addr", 64'(bus1.mem_addr), 64'(9));
      check("coll_no_ack", 64'(bus1.wr_ack), 64'(0));
      wait_ack(got);
      wr_req = 1'b0;
      check("coll_ack_cycle", 64'(got), 64'(n + 4));
      check("coll_wr_addr", 64'(bus1.mem_addr), 64'(100));
      check("coll_wr_we", 64'(bus1.mem_we), 64'(1));
      repeat (4) tick();

      // Strobe during WR_ISSUE: RD_ISSUE follows in the next cycle.
      wr_req  = 1'b1;
      wr_addr = 19'd300;
      wr_data = 8'h99;
      tick();
      check("pend_wr_ack", 64'(bus1.wr_ack), 64'(1));
      check("pend_wr_we", 64'(bus1.mem_we), 64'(1));
      wr_req = 1'b0;
      fetch(11'd1, 11'd2, 19'd802, 1'b1);
      check("pend_rd_addr", 64'(bus1.mem_addr), 64'(802));
      check("pend_rd_we", 64'(bus1.mem_we), 64'(0));
      repeat (5) tick();

      // Last legal word is written; one past the end is acked without a write.
      write_txn("wr_last", 19'd479999, 8'hA5, cyc + 1, 1'b1);
      check("wr_err_clear", 64'(bus1.wr_err), 64'(0));
      write_txn("wr_oob", 19'd480000, 8'h5C, cyc + 1, 1'b0);
      check("wr_err_set", 64'(bus1.wr_err), 64'(1));
      repeat (2) tick();

      // Reset during RD_WAIT clears everything and no pulse follows.
      fetch(11'd0, 11'd50, 19'd50, 1'b0);
      tick();
      #1 rst_n = 1'b0;
      #1 check("rst_mid_outs", outs1(), 64'(0));
      #1 rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         seen = seen | bus1.pix_data_valid | bus1.wr_ack;
      end
      check("rst_no_pulse", 64'(seen), 64'(0));

      // Strobes 3 cycles apart overrun the MEM_LAT=3 read but not MEM_LAT=1.
      check("ovr3_clear", 64'(bus3.rd_overrun), 64'(0));
      fetch(11'd0, 11'd20, 19'd20, 1'b1);
      repeat (2) tick();
      fetch(11'd0, 11'd21, 19'd21, 1'b1);
      check("ovr3_set", 64'(bus3.rd_overrun), 64'(1));
      check("ovr1_clear", 64'(bus1.rd_overrun), 64'(0));
      tick();
      check("ovr3_pix_valid", 64'(bus3.pix_data_valid), 64'(1));
      check("ovr3_pix_data", 64'(bus3.pix_data), 64'(fmem(19'd20)));
      repeat (6) tick();

      check("sb_empty", 64'(pix_q.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not reach its end");
      $fatal(1);
   end

endmodule
